// File: rtl/partial_sum_accumulator_pkg.sv
// Shared definitions for the partial-sum path between the MAC array and the accumulation FIFO.
// Window length default is common to the MAC array, this accumulator and the FIFO.
package partial_sum_accumulator_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int KERNEL_SIZE = 4;
  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/partial_sum_accumulator_sat_adder.sv
// Signed add that clamps to the representable range; ovf flags any clamp.
// Purely combinational, no backpressure.
module sat_adder #(
  parameter int DataWidth = 32
) (
  input  logic signed [DataWidth-1:0] a,
  input  logic signed [DataWidth-1:0] b,
  output logic signed [DataWidth-1:0] sum,
  output logic                        ovf
);

  localparam logic signed [DataWidth-1:0] MaxVal = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic signed [DataWidth-1:0] MinVal = {1'b1, {(DataWidth-1){1'b0}}};

  logic signed [DataWidth:0] wide;

  assign wide = {a[DataWidth-1], a} + {b[DataWidth-1], b};

  // Top two bits disagree exactly when the true sum is outside DataWidth range.
  always_comb begin
    sum = wide[DataWidth-1:0];
    ovf = 1'b0;
    if (wide[DataWidth] != wide[DataWidth-1]) begin
      ovf = 1'b1;
      sum = wide[DataWidth] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/partial_sum_accumulator.sv
// Sums each KernelSize-product window into one saturated partial sum and pushes it to the FIFO.
// Push one cycle after the last accept; while FifoFull holds a result, InReady is low.
module partial_sum_accumulator
  import partial_sum_accumulator_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH,
  parameter int KernelSize = KERNEL_SIZE,
  parameter int CountWidth = COUNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 InValid,
  input  logic [DataWidth-1:0] InData,
  output logic                 InReady,
  input  logic                 FifoFull,
  output logic                 Push,
  output logic [DataWidth-1:0] DataOut,
  output logic                 Busy,
  output logic                 Overflow
);

  localparam logic [CountWidth-1:0] LastCount = CountWidth'(KernelSize - 1);
  localparam bit                    SingleTap = (KernelSize == 1);

  state_t                      state_q, state_d;
  logic signed [DataWidth-1:0] sum_q;
  logic signed [DataWidth-1:0] add_sum;
  logic signed [DataWidth-1:0] result_q;
  logic [CountWidth-1:0]       count_q;
  logic                        overflow_q;
  logic                        add_ovf;
  logic                        accept;
  logic                        start;
  logic                        accum;
  logic                        close;

  sat_adder #(.DataWidth(DataWidth)) u_sat_adder (
    .a   (sum_q),
    .b   ($signed(InData)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign Push    = (state_q == HOLD) && !FifoFull;
  assign InReady = (state_q != HOLD) || !FifoFull;
  assign Busy    = (state_q != IDLE);
  assign accept  = InValid && InReady;
  // An accept in HOLD implies the pending result drains this cycle, so it opens a new window.
  assign start   = accept && ((state_q == IDLE) || (state_q == HOLD));
  assign accum   = accept && (state_q == ACCUM);
  assign close   = accum && (count_q == LastCount);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SingleTap ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (close) state_d = HOLD;
      end
      HOLD: begin
        if (Push) state_d = accept ? (SingleTap ? HOLD : ACCUM) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        sum_q   <= $signed(InData);
        count_q <= CountWidth'(1);
        if (SingleTap) result_q <= $signed(InData);
      end else if (accum) begin
        sum_q   <= add_sum;
        count_q <= count_q + 1'b1;
        if (add_ovf) overflow_q <= 1'b1;
        if (close)   result_q   <= add_sum;
      end
    end
  end

  assign DataOut  = result_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Directed bench for partial_sum_accumulator: window-level reference model plus literal push-log checks.
module tb_partial_sum_accumulator;
  import partial_sum_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        aclr;
  logic        InValid;
  logic [31:0] InData;
  logic        InReady;
  logic        FifoFull;
  logic        Push;
  logic [31:0] DataOut;
  logic        Busy;
  logic        Overflow;

  partial_sum_accumulator #(.DataWidth(32), .KernelSize(4), .CountWidth(8)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .FifoFull (FifoFull),
    .Push     (Push),
    .DataOut  (DataOut),
    .Busy     (Busy),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int stalls = 0;
  bit check_en = 1'b0;

  logic [31:0] log_q[$];
  int          pcyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window-level reference: products collected into a window, one pending result slot.
  int          m_cnt;
  longint      m_acc;
  bit          m_pend;
  logic [31:0] m_res;
  bit          m_ovf;

  always @(posedge clk) begin
    bit     acc_ok;
    longint v;
    cycle++;
    if (aclr) begin
      m_cnt = 0; m_acc = 0; m_pend = 0; m_res = '0; m_ovf = 0;
    end else begin
      acc_ok = InValid && (!m_pend || !FifoFull);
      if (m_pend && !FifoFull) m_pend = 0;
      if (acc_ok) begin
        v = longint'($signed(InData));
        if (m_cnt == 0) m_acc = v;
        else begin
          m_acc = m_acc + v;
          if (m_acc > longint'(SUM_MAX)) begin m_acc = longint'(SUM_MAX); m_ovf = 1; end
          if (m_acc < longint'(SUM_MIN)) begin m_acc = longint'(SUM_MIN); m_ovf = 1; end
        end
        m_cnt++;
        if (m_cnt == KERNEL_SIZE) begin
          m_pend = 1;
          m_res  = m_acc[31:0];
          m_cnt  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("push",     {31'b0, Push},     {31'b0, m_pend && !FifoFull});
      chk("inready",  {31'b0, InReady},  {31'b0, !m_pend || !FifoFull});
      chk("busy",     {31'b0, Busy},     {31'b0, (m_cnt > 0) || m_pend});
      chk("dataout",  DataOut,           m_res);
      chk("overflow", {31'b0, Overflow}, {31'b0, m_ovf});
    end
    if (Push === 1'b1) begin
      log_q.push_back(DataOut);
      pcyc_q.push_back(cycle);
    end
  end

  task automatic send(input logic [31:0] d);
    int n = 0;
    bit ok = 1'b0;
    InValid = 1'b1;
    InData  = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = InReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept for 0x%08h within 50 cycles, required an accept", d);
    end
    if (n > 1) stalls++;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (log_q.size() > i) ? log_q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aclr = 1'b1; InValid = 1'b0; InData = '0; FifoFull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_push",     {31'b0, Push},     32'd0);
    chk("rst_inready",  {31'b0, InReady},  32'd1);
    chk("rst_busy",     {31'b0, Busy},     32'd0);
    chk("rst_dataout",  DataOut,           32'd0);
    chk("rst_overflow", {31'b0, Overflow}, 32'd0);
    @(posedge clk); #1;

    // 1: single window
    log_q.delete(); pcyc_q.delete();
    for (int i = 1; i <= 4; i++) send(32'(i));
    InValid = 1'b0;
    @(negedge clk);
    chk("t1_push", {31'b0, Push}, 32'd1);
    chk("t1_data", DataOut, 32'd10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_push_off", {31'b0, Push}, 32'd0);
    chk("t1_busy_off", {31'b0, Busy}, 32'd0);
    idle(2);
    chk("t1_npush", 32'(log_q.size()), 32'd1);
    chk("t1_val", log_at(0), 32'd10);

    // 2: back-pressure
    log_q.delete(); pcyc_q.delete();
    for (int i = 0; i < 3; i++) send(32'd5);
    FifoFull = 1'b1;
    send(32'd5);
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_push",  {31'b0, Push},    32'd0);
      chk("t2_hold_ready", {31'b0, InReady}, 32'd0);
      chk("t2_hold_data",  DataOut,          32'd20);
      @(posedge clk); #1;
    end
    FifoFull = 1'b0;
    @(negedge clk);
    chk("t2_release_push", {31'b0, Push}, 32'd1);
    @(posedge clk); #1;
    idle(2);
    chk("t2_npush", 32'(log_q.size()), 32'd1);
    chk("t2_val", log_at(0), 32'd20);

    // 3: streaming 1..12
    log_q.delete(); pcyc_q.delete(); stalls = 0;
    for (int i = 1; i <= 12; i++) send(32'(i));
    idle(3);
    chk("t3_npush", 32'(log_q.size()), 32'd3);
    chk("t3_val0", log_at(0), 32'd10);
    chk("t3_val1", log_at(1), 32'd26);
    chk("t3_val2", log_at(2), 32'd42);
    chk("t3_gap01", (pcyc_q.size() > 1) ? 32'(pcyc_q[1] - pcyc_q[0]) : 32'hffff_ffff, 32'd4);
    chk("t3_gap12", (pcyc_q.size() > 2) ? 32'(pcyc_q[2] - pcyc_q[1]) : 32'hffff_ffff, 32'd4);
    chk("t3_stalls", 32'(stalls), 32'd0);

    // 4: saturation, then a negative window
    log_q.delete(); pcyc_q.delete();
    send(32'h7FFF_FFFF); send(32'd1); send(32'd0); send(32'd0);
    idle(2);
    chk("t4_sat_val", log_at(0), 32'h7FFF_FFFF);
    chk("t4_ovf", {31'b0, Overflow}, 32'd1);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
    idle(2);
    chk("t4_neg_val", log_at(1), 32'hFFFF_FFFC);
    chk("t4_ovf_sticky", {31'b0, Overflow}, 32'd1);

    // 5: reset mid-window
    log_q.delete(); pcyc_q.delete();
    send(32'd7); send(32'd7);
    InValid = 1'b0;
    aclr = 1'b1;
    @(posedge clk); #1;
    aclr = 1'b0;
    idle(2);
    chk("t5_nopush", 32'(log_q.size()), 32'd0);
    chk("t5_ovf_clr", {31'b0, Overflow}, 32'd0);
    for (int i = 0; i < 4; i++) send(32'd5);
    idle(2);
    chk("t5_val", log_at(0), 32'd20);
    chk("t5_npush", 32'(log_q.size()), 32'd1);
    chk("t5_ovf", {31'b0, Overflow}, 32'd0);

    // 6: gapped input
    log_q.delete(); pcyc_q.delete();
    for (int i = 1; i <= 4; i++) begin
      send(32'(i));
      idle(2);
    end
    idle(2);
    chk("t6_npush", 32'(log_q.size()), 32'd1);
    chk("t6_val", log_at(0), 32'd10);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/partial_sum_accumulator.md
Name: partial_sum_accumulator

Overview:
- Upstream neighbour of the accumulation FIFO in the convolution engine.
- Consumes a stream of signed MAC products and sums each window of KernelSize products into one saturated partial sum.
- Presents each sum to the FIFO with a one-cycle Push, honouring the FIFO's Full back-pressure, and stalls the MAC stream while a result cannot be delivered.

Parameters:
- DataWidth, 32, width of products, accumulator and DataOut (signed two's complement).
- KernelSize, 4, number of products per window; legal range 1..255.
- CountWidth, 8, width of the window counter; must satisfy 2^CountWidth > KernelSize.

Ports:
- clk  input  1  rising-edge clock.
- aclr  input  1  reset, synchronous, active-high.
- InValid  input  1  InData holds a valid product this cycle.
- InData  input  DataWidth  signed product.
- InReady  output  1  block accepts InData this cycle.
- FifoFull  input  1  Full flag from the downstream FIFO.
- Push  output  1  write strobe to the FIFO, sampled by the FIFO on the same clk edge.
- DataOut  output  DataWidth  completed partial sum; valid whenever Push=1.
- Busy  output  1  high when in ACCUM or HOLD (window in progress or result pending).
- Overflow  output  1  sticky saturation flag.

Behaviour:
- Reset: when aclr=1 at an edge, the block goes to IDLE with sum=0, count=0, DataOut=0, Overflow=0.
  - In the cycle after reset: Push=0, InReady=1, Busy=0.
  - aclr mid-window or in HOLD discards the partial or pending result; no Push is issued.
- Accept: accept = InValid & InReady.
- States: IDLE, ACCUM, HOLD.
- IDLE: InReady=1.
  - On accept: sum <= sext(InData), count <= 1.
  - Next state is HOLD if KernelSize==1, otherwise ACCUM.
- ACCUM: InReady=1.
  - On accept: sum <= sat(sum+InData), count <= count+1.
  - If count==KernelSize-1 at the accept, the result register is loaded with the saturated sum and the next state is HOLD.
  - No accept: hold all state.
- HOLD:
  - Push = ~FifoFull, combinational from state and FifoFull.
  - DataOut is stable for the whole HOLD period.
  - InReady = ~FifoFull, so a new window can start in the same cycle the result drains.
  - Push=1 and no accept: go to IDLE.
  - Push=1 with accept: start a new window as in IDLE (next state ACCUM, or HOLD again if KernelSize==1).
  - FifoFull=1: Push=0, InReady=0, remain in HOLD indefinitely.
- Latency: Push can assert the cycle after the last accept of a window. With FifoFull=0 throughout, sustained throughput is one product per cycle with no bubbles.
- Saturation:
  - sum+InData is computed at DataWidth+1 bits.
  - Above 2^(DataWidth-1)-1 the result clamps to the max; below -2^(DataWidth-1) it clamps to the min.
  - Any clamp sets Overflow=1 until aclr.
  - After a clamp, later additions in the same window continue from the clamped value.
- Push is never asserted while FifoFull=1, and never for more than one cycle per window.
- DataOut outside HOLD holds the last result (0 after reset).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - signed max/min constants derived from DataWidth;
  - KernelSize default shared with the FIFO and MAC array.
- One sub-module, sat_adder: combinational DataWidth-bit signed add with clamp and an overflow output.
- The FSM, counter and result register stay in the top module.

Test Plan (KernelSize=4, DataWidth=32):
1. Window sum: with FifoFull=0, feed 1,2,3,4 on consecutive cycles.
   - Push=1 for exactly one cycle after the 4th accept, with DataOut=10.
   - Busy returns to 0 the following cycle.
2. Back-pressure: FifoFull=1 before the 4th accept of 5,5,5,5, held 3 cycles.
   - In HOLD: Push=0, InReady=0, DataOut=20 stable.
   - Push=1 in the first cycle FifoFull=0.
3. Streaming: with FifoFull=0 and InValid=1 continuously, feed 1..12.
   - Pushes of 10, 26 and 42 spaced 4 cycles apart.
   - InReady never drops.
4. Saturation: feed 0x7FFFFFFF,1,0,0 → DataOut=0x7FFFFFFF and Overflow=1.
   - Next window -1,-1,-1,-1 → DataOut=0xFFFFFFFC.
   - Overflow stays 1.
5. Reset mid-window: accept 7,7, then assert aclr for one cycle.
   - No Push is issued.
   - Window 5,5,5,5 then gives DataOut=20, and Overflow=0.
6. Gapped input: feed 1,2,3,4 with InValid low for 2 cycles between each product → single Push with DataOut=10.
